usart_bus_sequencer: RTL
========================

USART_BUS_SEQUENCER -- requirements
Module: usart_bus_sequencer

Interface
REQ-001 SHALL have parameter UDR_ADDR, default 12'h0C6, UDRn address.
REQ-002 SHALL have parameter UCSRA_ADDR, default 12'h0C0, UCSRnA address.
REQ-003 SHALL have parameter UCSRB_ADDR, default 12'h0C1, UCSRnB address.
REQ-004 SHALL have parameter UCSRC_ADDR, default 12'h0C2, UCSRnC address.
REQ-005 SHALL have parameter UBRRH_ADDR, default 12'h0C5, UBRRnH address.
REQ-006 SHALL have parameter UBRRL_ADDR, default 12'h0C4, UBRRnL address.
REQ-007 SHALL have port cp2, input, 1: single clock; all state on rising edge.
REQ-008 SHALL have port ireset, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port cfg_start, input, 1: pulse that starts the configuration sequence.
REQ-010 SHALL have port cfg_ubrr, input, 12: baud divisor.
REQ-011 SHALL have ports cfg_ucsra, cfg_ucsrb, cfg_ucsrc, input, 8 each: control register images.
REQ-012 SHALL have port cfg_done, output, 1: high while configured and polling.
REQ-013 SHALL have ports tx_valid (input, 1), tx_data (input, 8) and tx_ready (output, 1): byte-to-send handshake.
REQ-014 SHALL have ports rx_valid (output, 1) and rx_data (output, 8): received byte, one-cycle pulse.
REQ-015 SHALL have port bus_err, output, 1: sticky flag, read without out_en.
REQ-016 SHALL have ports ram_Addr (output, 12), ramre (output, 1), ramwe (output, 1) and dbus_out (output, 8): bus master to USARTn.
REQ-017 SHALL have ports dbus_in (input, 8) and out_en (input, 1): USARTn read data and its valid.

Function
REQ-018 SHALL implement states IDLE, CFG_H, CFG_L, CFG_A, CFG_C, CFG_B, POLL, RD_UDR and WR_UDR.
REQ-019 SHALL, on cfg_start sampled high in any state, capture all cfg_* inputs into shadow registers, clear cfg_done, bus_err and the tx holding register, and enter CFG_H.
REQ-020 SHALL, in CFG_* states, perform one write per cycle in order H, L, A, C, B: ramwe=1, ram_Addr = matching *_ADDR; dbus_out = {4'b0,ubrr[11:8]}, ubrr[7:0], ucsra, ucsrc, ucsrb.
REQ-021 SHALL order the writes so UBRRnL follows UBRRnH and UCSRnB (TXEN/RXEN) is written last; after CFG_B, go to POLL.
REQ-022 SHALL have latency cfg_start edge to cfg_done=1 of exactly 6 cycles; cfg_done stays high in POLL, RD_UDR and WR_UDR.
REQ-023 SHALL, in POLL, drive ramre=1, ram_Addr=UCSRA_ADDR and sample dbus_in at the closing edge.
REQ-024 SHALL branch from the POLL sample as follows: out_en=0 -> set bus_err, stay in POLL; bit7 (RXC)=1 -> RD_UDR; else bit5 (UDRE)=1 and tx holding full -> WR_UDR; else stay in POLL.
REQ-025 SHALL give RX priority over TX when RXC and UDRE are both set.
REQ-026 SHALL, in RD_UDR, drive ramre=1, ram_Addr=UDR_ADDR; if out_en=1, register dbus_in to rx_data and pulse rx_valid for one cycle after the edge; if out_en=0, set bus_err with no rx_valid; then go to POLL.
REQ-027 SHALL, in WR_UDR, drive ramwe=1, ram_Addr=UDR_ADDR, dbus_out=holding byte; clear the holding register at the edge; then go to POLL.
REQ-028 SHALL compute tx_ready = cfg_done & ~holding_full; a byte is accepted on tx_valid&tx_ready at an edge.
REQ-029 SHALL make an accepted byte eligible in the next POLL cycle (accept at edge k, earliest UDR write in cycle k+2).
REQ-030 SHALL never assert ramre and ramwe together; in IDLE, ram_Addr, dbus_out, ramre and ramwe SHALL be 0.
REQ-031 SHALL let cfg_start win over a coincident RD_UDR completion: rx_valid suppressed and no data retained.
REQ-032 SHALL keep bus_err set until reset or cfg_start.

Reset
REQ-033 SHALL, on ireset=1, immediately (asynchronously) force state IDLE and all outputs and shadow/holding registers to 0, independent of cp2.
REQ-034 SHALL, after ireset deasserts, remain in IDLE with no bus activity until cfg_start.

Verification
REQ-035 SHALL cover: cfg_start with ubrr=0x411, ucsra=0x00, ucsrb=0x1D, ucsrc=0x6E -> writes (0x0C5,0x04),(0x0C4,0x11),(0x0C0,0x00),(0x0C2,0x6E),(0x0C1,0x1D) in consecutive cycles; cfg_done=1 at edge 6.
REQ-036 SHALL cover: model UCSRA=0x20, tx_data=0x65 accepted -> exactly one write (0x0C6,0x65) 2 cycles later; tx_ready low for that span.
REQ-037 SHALL cover: model UCSRA=0xA0, UDR=0x75, tx byte pending -> UDR read first, rx_valid pulse with rx_data=0x75, UDR write on a following pass.
REQ-038 SHALL cover: out_en held 0 during polling -> bus_err=1, no rx_valid, no UDR access; subsequent cfg_start clears bus_err.
REQ-039 SHALL cover: cfg_start while a tx byte is pending -> byte dropped, full 5-write sequence reissued, tx_ready=0 until cfg_done.
REQ-040 SHALL cover: ireset pulsed during CFG_L -> ramwe, cfg_done and ram_Addr go to 0 immediately; no further writes until a new cfg_start.

Source files
------------

// File: rtl/usart_bus_sequencer_if.sv
// Byte-wide register bus between the USART sequencer and the USARTn block.
// The sequencer is the master; the USART returns read data with out_en.
interface usart_bus_sequencer_if;
    logic [11:0] ram_Addr;
    logic        ramre;
    logic        ramwe;
    logic [7:0]  dbus_out;
    logic [7:0]  dbus_in;
    logic        out_en;

    modport master (
        output ram_Addr, ramre, ramwe, dbus_out,
        input  dbus_in, out_en
    );

    modport slave (
        input  ram_Addr, ramre, ramwe, dbus_out,
        output dbus_in, out_en
    );
endinterface

// File: rtl/usart_bus_sequencer.sv
// Configures a USARTn over the register bus, then polls UCSRnA and moves
// bytes between the TX/RX handshakes and UDRn.
module usart_bus_sequencer #(
    parameter logic [11:0] UDR_ADDR   = 12'h0C6,
    parameter logic [11:0] UCSRA_ADDR = 12'h0C0,
    parameter logic [11:0] UCSRB_ADDR = 12'h0C1,
    parameter logic [11:0] UCSRC_ADDR = 12'h0C2,
    parameter logic [11:0] UBRRH_ADDR = 12'h0C5,
    parameter logic [11:0] UBRRL_ADDR = 12'h0C4
) (
    input  logic                  cp2,
    input  logic                  ireset,
    input  logic                  cfg_start,
    input  logic [11:0]           cfg_ubrr,
    input  logic [7:0]            cfg_ucsra,
    input  logic [7:0]            cfg_ucsrb,
    input  logic [7:0]            cfg_ucsrc,
    output logic                  cfg_done,
    input  logic                  tx_valid,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    output logic                  bus_err,
    usart_bus_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, CFG_H, CFG_L, CFG_A, CFG_C, CFG_B, POLL, RD_UDR, WR_UDR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] ubrr_q;
    logic [7:0]  ucsra_q;
    logic [7:0]  ucsrb_q;
    logic [7:0]  ucsrc_q;
    logic [7:0]  hold_q;
    logic        hold_full;
    logic        accept;

    assign cfg_done = (state == POLL) | (state == RD_UDR) | (state == WR_UDR);
    assign tx_ready = cfg_done & ~hold_full;
    assign accept   = tx_valid & tx_ready;

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) state <= IDLE;
        else        state <= state_nxt;
    end

    // UCSRnB goes last so TXEN/RXEN only rise once baud and framing are set
    always_comb begin
        state_nxt = state;
        if (cfg_start) begin
            state_nxt = CFG_H;
        end else begin
            unique case (state)
                IDLE:  state_nxt = IDLE;
                CFG_H: state_nxt = CFG_L;
                CFG_L: state_nxt = CFG_A;
                CFG_A: state_nxt = CFG_C;
                CFG_C: state_nxt = CFG_B;
                CFG_B: state_nxt = POLL;
                POLL: begin
                    if (!bus.out_en)                        state_nxt = POLL;
                    else if (bus.dbus_in[7])                state_nxt = RD_UDR;
                    else if (bus.dbus_in[5] && hold_full)   state_nxt = WR_UDR;
                    else                                    state_nxt = POLL;
                end
                RD_UDR: state_nxt = POLL;
                WR_UDR: state_nxt = POLL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ram_Addr = 12'h000;
        bus.ramre    = 1'b0;
        bus.ramwe    = 1'b0;
        bus.dbus_out = 8'h00;
        unique case (state)
            CFG_H: begin
                bus.ramwe    = 1'b1;
                bus.ram_Addr = UBRRH_ADDR;
                bus.dbus_out = {4'b0000, ubrr_q[11:8]};
            end
            CFG_L: begin
                bus.ramwe    = 1'b1;
                bus.ram_Addr = UBRRL_ADDR;
                bus.dbus_out = ubrr_q[7:0];
            end
            CFG_A: begin
                bus.ramwe    = 1'b1;
                bus.ram_Addr = UCSRA_ADDR;
                bus.dbus_out = ucsra_q;
            end
            CFG_C: begin
                bus.ramwe    = 1'b1;
                bus.ram_Addr = UCSRC_ADDR;
                bus.dbus_out = ucsrc_q;
            end
            CFG_B: begin
                bus.ramwe    = 1'b1;
                bus.ram_Addr = UCSRB_ADDR;
                bus.dbus_out = ucsrb_q;
            end
            POLL: begin
                bus.ramre    = 1'b1;
                bus.ram_Addr = UCSRA_ADDR;
            end
            RD_UDR: begin
                bus.ramre    = 1'b1;
                bus.ram_Addr = UDR_ADDR;
            end
            WR_UDR: begin
                bus.ramwe    = 1'b1;
                bus.ram_Addr = UDR_ADDR;
                bus.dbus_out = hold_q;
            end
            default: ;
        endcase
    end

    // A restart discards any pending TX byte and any read completing now
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            ubrr_q    <= 12'h000;
            ucsra_q   <= 8'h00;
            ucsrb_q   <= 8'h00;
            ucsrc_q   <= 8'h00;
            hold_q    <= 8'h00;
            hold_full <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cfg_start) begin
                ubrr_q    <= cfg_ubrr;
                ucsra_q   <= cfg_ucsra;
                ucsrb_q   <= cfg_ucsrb;
                ucsrc_q   <= cfg_ucsrc;
                hold_q    <= 8'h00;
                hold_full <= 1'b0;
                bus_err   <= 1'b0;
            end else begin
                if (state == POLL && !bus.out_en) bus_err <= 1'b1;
                if (state == RD_UDR) begin
                    if (bus.out_en) begin
                        rx_data  <= bus.dbus_in;
                        rx_valid <= 1'b1;
                    end else begin
                        bus_err <= 1'b1;
                    end
                end
                if (state == WR_UDR) begin
                    hold_q    <= 8'h00;
                    hold_full <= 1'b0;
                end
                if (accept) begin
                    hold_q    <= tx_data;
                    hold_full <= 1'b1;
                end
            end
        end
    end

endmodule
